arp_crypto_input_arbiter: RTL and testbench
===========================================

ARP_CRYPTO_INPUT_ARBITER -- requirements
Module: arp_crypto_input_arbiter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, SHALL set the tdata width of both slave ports and the master port.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, SHALL set the tuser width of all ports.
REQ-003 Port axis_aclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 Port axis_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Ports s0_axis_tdata/tkeep/tuser/tvalid/tlast  in  DATA/DATA/8/TUSER/1/1  SHALL form requester 0's AXI-Stream input; s0_axis_tready  out  1.
REQ-006 Ports s1_axis_* SHALL mirror s0_axis_* for requester 1.
REQ-007 Ports m_axis_tdata/tkeep/tuser/tvalid/tlast  out, m_axis_tready  in  SHALL form the single output toward the ARP crypto datapath.
REQ-008 Port clear_counters  in  1  SHALL synchronously zero both packet counters.
REQ-009 Ports pkt_cnt0, pkt_cnt1  out  32  SHALL count packets forwarded from s0 and s1.

Function
REQ-010 The block SHALL arbitrate at packet granularity; a grant is held from the first beat until the beat with tlast is accepted.
REQ-011 States SHALL be IDLE and PKT; reset state is IDLE.
REQ-012 In IDLE, if any s*_axis_tvalid is high, the block SHALL latch grant and last_grant selection and enter PKT next cycle; no beat is accepted in IDLE (one-cycle arbitration bubble).
REQ-013 Round-robin: if both valid, grant SHALL go to the input opposite last_grant; if one valid, grant SHALL go to it.
REQ-014 In PKT, sN_axis_tready SHALL equal (grant==N) AND (!m_axis_tvalid OR m_axis_tready); non-granted tready SHALL be 0.
REQ-015 Output SHALL be a one-stage register: on accepted input beat, all m_axis_* fields load next edge with m_axis_tvalid=1; latency 1 cycle.
REQ-016 With m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* SHALL hold stable.
REQ-017 m_axis_tvalid SHALL clear on the edge where m_axis_tready=1 and no new beat is accepted.
REQ-018 On accepted beat with tlast=1, the block SHALL return to IDLE, set last_grant=grant, and increment pkt_cntN; single-beat packets SHALL behave identically.
REQ-019 Counters SHALL wrap modulo 2^32; clear_counters coincident with an increment SHALL win (result 0).
REQ-020 Input beats SHALL never be dropped, duplicated or reordered.

Reset
REQ-021 Asserting axis_reset SHALL immediately force: state=IDLE, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, s0/s1 tready=0, pkt_cnt0=pkt_cnt1=0, last_grant=1 (s0 wins first contention).
REQ-022 Reset mid-packet SHALL abandon the packet; after release the block restarts in IDLE with no residual output beat.

Configuration
REQ-023 Macro ARP_CRYPTO_ARB_ARP_PRIORITY_EN, when defined, SHALL make IDLE arbitration favour an input whose current head beat has tdata[111:96]==16'h0608 (ARP Ethertype, byte-swapped); if both or neither match, REQ-013 applies.
REQ-024 Without the macro, arbitration SHALL be pure round-robin and no tdata inspection logic SHALL be synthesised.

Structure
REQ-025 Shared package arp_crypto_pkg SHALL hold state encoding (IDLE, PKT), ETH_TYPE_ARP=16'h0608, TYPE_HIGH=111, TYPE_LOW=96.
REQ-026 The output register stage SHALL be the single sub-module arp_crypto_axis_reg (one-stage AXIS register with hold-under-backpressure); arbitration FSM and counters remain in the top.

Verification
REQ-027 Both inputs continuously offer 3-beat packets, m_axis_tready=1 -> output order s0,s1,s0,s1; pkt_cnt0=pkt_cnt1=2 after four packets; one idle cycle between packets.
REQ-028 s0 sends 4-beat packet, m_axis_tready toggles 1,0,1,0 -> all 4 beats appear once, in order, stable while tready=0; s1_axis_tready=0 throughout.
REQ-029 s1 alone sends single-beat packet (tlast on beat 1) -> appears 2 cycles after tvalid, pkt_cnt1=1, state back to IDLE.
REQ-030 axis_reset asserted on beat 2 of a 4-beat s0 packet -> m_axis_tvalid=0 immediately, counters 0; next contention grants s0.
REQ-031 pkt_cnt0 preloaded to 32'hFFFFFFFF by 2^32-1 packets (or force) then one s0 packet -> 0; clear_counters with simultaneous tlast -> 0.
REQ-032 With ARP_CRYPTO_ARB_ARP_PRIORITY_EN, last_grant=1, s0 IPv4 (16'h0008) and s1 ARP (16'h0608) both valid -> s1 granted first; without macro -> s0 first.

Source files
------------

// File: rtl/arp_crypto_pkg.sv
// rtl/arp_crypto_pkg.sv - shared arbiter state encoding, ARP match constants and round-robin helper
package arp_crypto_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  // Ethertype sits byte-swapped in the little-endian beat, hence 0x0608 for ARP
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0608;
  localparam int          TYPE_HIGH    = 111;
  localparam int          TYPE_LOW     = 96;

  function automatic logic rr_pick(input logic valid0, input logic valid1, input logic last_grant);
    if (valid0 && valid1) begin
      return !last_grant;
    end
    return valid1;
  endfunction

endpackage

// File: rtl/arp_crypto_axis_reg.sv
// rtl/arp_crypto_axis_reg.sv - one-stage AXI-Stream output register holding its beat under backpressure
module arp_crypto_axis_reg #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [USER_WIDTH-1:0]   in_tuser,
  input  logic                    in_tlast,
  output logic                    can_load,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  // The stage is free when empty or when its current beat leaves this cycle
  assign can_load = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= in_tdata;
      m_axis_tkeep  <= in_tkeep;
      m_axis_tuser  <= in_tuser;
      m_axis_tlast  <= in_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/arp_crypto_input_arbiter.sv
// rtl/arp_crypto_input_arbiter.sv - two-input packet round-robin arbiter; ARP_CRYPTO_ARB_ARP_PRIORITY_EN adds ARP-first arbitration
module arp_crypto_input_arbiter
  import arp_crypto_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                           axis_aclk,
  input  logic                           axis_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s0_axis_tuser,
  input  logic                           s0_axis_tvalid,
  input  logic                           s0_axis_tlast,
  output logic                           s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s1_axis_tuser,
  input  logic                           s1_axis_tvalid,
  input  logic                           s1_axis_tlast,
  output logic                           s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,

  input  logic                           clear_counters,
  output logic [31:0]                    pkt_cnt0,
  output logic [31:0]                    pkt_cnt1
);

  arb_state_t state;
  logic       grant;
  logic       last_grant;
  logic       next_grant;
  logic       can_load;
  logic       accept;
  logic       accept_last;

  logic [C_AXIS_DATA_WIDTH-1:0]   sel_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] sel_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  sel_tuser;
  logic                           sel_tlast;

`ifdef ARP_CRYPTO_ARB_ARP_PRIORITY_EN
  logic s0_is_arp;
  logic s1_is_arp;

  assign s0_is_arp = (s0_axis_tdata[TYPE_HIGH:TYPE_LOW] == ETH_TYPE_ARP);
  assign s1_is_arp = (s1_axis_tdata[TYPE_HIGH:TYPE_LOW] == ETH_TYPE_ARP);

  // An ARP head beat only wins when exactly one contender carries it
  always_comb begin
    next_grant = rr_pick(s0_axis_tvalid, s1_axis_tvalid, last_grant);
    if (s0_axis_tvalid && s1_axis_tvalid && (s0_is_arp != s1_is_arp)) begin
      next_grant = s1_is_arp;
    end
  end
`else
  assign next_grant = rr_pick(s0_axis_tvalid, s1_axis_tvalid, last_grant);
`endif

  assign s0_axis_tready = (state == PKT) && !grant && can_load;
  assign s1_axis_tready = (state == PKT) &&  grant && can_load;

  assign accept      = grant ? (s1_axis_tvalid && s1_axis_tready)
                             : (s0_axis_tvalid && s0_axis_tready);
  assign sel_tdata   = grant ? s1_axis_tdata : s0_axis_tdata;
  assign sel_tkeep   = grant ? s1_axis_tkeep : s0_axis_tkeep;
  assign sel_tuser   = grant ? s1_axis_tuser : s0_axis_tuser;
  assign sel_tlast   = grant ? s1_axis_tlast : s0_axis_tlast;
  assign accept_last = accept && sel_tlast;

  // last_grant resets to 1 so that s0 wins the first contention
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            grant <= next_grant;
            state <= PKT;
          end
        end
        PKT: begin
          if (accept_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear_counters takes precedence over a same-cycle packet completion
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (clear_counters) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (accept_last) begin
      if (grant) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end else begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
    end
  end

  arp_crypto_axis_reg #(
    .DATA_WIDTH (C_AXIS_DATA_WIDTH),
    .USER_WIDTH (C_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk           (axis_aclk),
    .rst           (axis_reset),
    .load          (accept),
    .in_tdata      (sel_tdata),
    .in_tkeep      (sel_tkeep),
    .in_tuser      (sel_tuser),
    .in_tlast      (sel_tlast),
    .can_load      (can_load),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_arp_crypto_input_arbiter.sv
// tb/tb_arp_crypto_input_arbiter.sv - self-checking bench for arp_crypto_input_arbiter (honours ARP_CRYPTO_ARB_ARP_PRIORITY_EN)
module tb_arp_crypto_input_arbiter;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          axis_aclk;
  logic          axis_reset;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic          clear_counters;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  arp_crypto_input_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .axis_aclk      (axis_aclk),
    .axis_reset     (axis_reset),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tuser  (s0_axis_tuser),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tuser  (s1_axis_tuser),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .clear_counters (clear_counters),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       q0[$], q1[$], exp_q[$];
  int          l0[$], l1[$];
  int          model_last;
  logic [31:0] exp_cnt0, exp_cnt1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat(input logic [15:0] etype, input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    b.data[111:96] = etype;
    b.keep = $urandom;
    for (int i = 0; i < UW / 32; i++) b.user[i*32 +: 32] = $urandom;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t out_beat();
    return {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
  endfunction

  task automatic add_pkt(input int src, input int len, input logic [15:0] etype);
    for (int i = 0; i < len; i++) begin
      if (src == 0) q0.push_back(rand_beat(etype, i == len - 1));
      else          q1.push_back(rand_beat(etype, i == len - 1));
    end
    if (src == 0) l0.push_back(len);
    else          l1.push_back(len);
  endtask

  // Packet-level reference: with both sources continuously offering, whole
  // packets alternate; a lone source is served back to back.
  task automatic build_expected();
    int p0 = 0, p1 = 0, i0 = 0, i1 = 0, pick;
    while (p0 < l0.size() || p1 < l1.size()) begin
      if (p0 < l0.size() && p1 < l1.size()) begin
        pick = (model_last == 0) ? 1 : 0;
`ifdef ARP_CRYPTO_ARB_ARP_PRIORITY_EN
        begin
          logic a0, a1;
          a0 = (q0[i0].data[111:96] == 16'h0608);
          a1 = (q1[i1].data[111:96] == 16'h0608);
          if (a0 != a1) pick = a1 ? 1 : 0;
        end
`endif
      end else begin
        pick = (p0 < l0.size()) ? 0 : 1;
      end
      if (pick == 0) begin
        for (int k = 0; k < l0[p0]; k++) exp_q.push_back(q0[i0 + k]);
        i0 += l0[p0]; p0++; exp_cnt0++;
      end else begin
        for (int k = 0; k < l1[p1]; k++) exp_q.push_back(q1[i1 + k]);
        i1 += l1[p1]; p1++; exp_cnt1++;
      end
      model_last = pick;
    end
    l0.delete();
    l1.delete();
  endtask

  // mode 0: sink always ready, 1: ready toggles 1,0,1,0, 2: random ready
  task automatic run_traffic(input int mode, input bit chk_gap, input bit chk_s1);
    int    cyc = 0, last_cyc = -100;
    bit    after_last = 0, hold = 0, done = 0;
    beat_t held, obs, acc;
    while (!done && cyc < 3000) begin
      @(negedge axis_aclk);
      obs = out_beat();
      if (hold) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_stable", obs, held);
      end
      s0_axis_tvalid = (q0.size() != 0);
      if (q0.size() != 0) {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = q0[0];
      s1_axis_tvalid = (q1.size() != 0);
      if (q1.size() != 0) {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = q1[0];
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (chk_s1) check("s1_tready_low", s1_axis_tready, 1'b0);
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("out_beat", obs, exp_q.pop_front());
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held = obs;
      if ((s0_axis_tvalid && s0_axis_tready) || (s1_axis_tvalid && s1_axis_tready)) begin
        acc = (s0_axis_tvalid && s0_axis_tready) ? q0.pop_front() : q1.pop_front();
        if (chk_gap && after_last) check("pkt_gap", cyc - last_cyc, 2);
        after_last = acc.last;
        if (acc.last) last_cyc = cyc;
      end
      done = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0);
      cyc++;
    end
    check("traffic_done", done, 1'b1);
    @(negedge axis_aclk);
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    m_axis_tready  = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge axis_aclk);
    axis_reset = 1'b1;
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    model_last = 1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
  endtask

  initial begin
    beat_t b, b1;
    int    n0, n1;
    axis_reset = 1'b1;
    clear_counters = 1'b0;
    m_axis_tready = 1'b1;
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast, s0_axis_tvalid} = '0;
    {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast, s1_axis_tvalid} = '0;
    model_last = 1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;

    repeat (2) @(negedge axis_aclk);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_beat", out_beat(), '0);
    check("rst_s0_tready", s0_axis_tready, 1'b0);
    check("rst_s1_tready", s1_axis_tready, 1'b0);
    check("rst_cnt0", pkt_cnt0, 32'd0);
    check("rst_cnt1", pkt_cnt1, 32'd0);
    axis_reset = 1'b0;

    // Both inputs offering 3-beat packets: s0,s1,s0,s1 with one bubble each
    for (int i = 0; i < 2; i++) begin
      add_pkt(0, 3, 16'h0008);
      add_pkt(1, 3, 16'h0008);
    end
    build_expected();
    run_traffic(0, 1'b1, 1'b0);
    check("rr_cnt0", pkt_cnt0, 32'd2);
    check("rr_cnt1", pkt_cnt1, 32'd2);

    // s0 alone, 4 beats under toggling backpressure
    add_pkt(0, 4, 16'h0008);
    build_expected();
    run_traffic(1, 1'b0, 1'b1);
    check("bp_cnt0", pkt_cnt0, exp_cnt0);

    // s1 single-beat packet: output two cycles after tvalid
    b = rand_beat(16'h0008, 1'b1);
    @(negedge axis_aclk);
    {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = b;
    s1_axis_tvalid = 1'b1;
    #1 check("single_idle_tready", s1_axis_tready, 1'b0);
    @(negedge axis_aclk);
    #1 check("single_pkt_tready", s1_axis_tready, 1'b1);
    check("single_no_early_out", m_axis_tvalid, 1'b0);
    @(negedge axis_aclk);
    s1_axis_tvalid = 1'b0;
    exp_cnt1++;
    model_last = 1;
    #1 check("single_m_tvalid", m_axis_tvalid, 1'b1);
    check("single_beat", out_beat(), b);
    check("single_back_idle", s1_axis_tready, 1'b0);
    check("single_cnt1", pkt_cnt1, exp_cnt1);
    @(negedge axis_aclk);
    #1 check("single_drained", m_axis_tvalid, 1'b0);

    // Reset while beat 2 of a 4-beat s0 packet is offered
    b  = rand_beat(16'h0008, 1'b0);
    b1 = rand_beat(16'h0008, 1'b0);
    @(negedge axis_aclk);
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = b;
    s0_axis_tvalid = 1'b1;
    @(negedge axis_aclk);
    #1 check("midrst_tready", s0_axis_tready, 1'b1);
    @(negedge axis_aclk);
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = b1;
    #1 check("midrst_beat0", out_beat(), b);
    #1 axis_reset = 1'b1;
    #1 check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_beat", out_beat(), '0);
    check("midrst_s0_tready", s0_axis_tready, 1'b0);
    check("midrst_cnt0", pkt_cnt0, 32'd0);
    check("midrst_cnt1", pkt_cnt1, 32'd0);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    s0_axis_tvalid = 1'b0;
    model_last = 1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_aclk);
      #1 check("midrst_no_residual", m_axis_tvalid, 1'b0);
    end
    add_pkt(0, 1, 16'h0008);
    add_pkt(1, 1, 16'h0008);
    build_expected();
    run_traffic(0, 1'b0, 1'b0);
    check("post_rst_cnt0", pkt_cnt0, exp_cnt0);
    check("post_rst_cnt1", pkt_cnt1, exp_cnt1);

    // Counter wrap from all-ones
    @(negedge axis_aclk);
    force dut.pkt_cnt0 = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt0;
    exp_cnt0 = 32'hFFFF_FFFF;
    #1 check("wrap_preload", pkt_cnt0, exp_cnt0);
    add_pkt(0, 2, 16'h0008);
    build_expected();
    run_traffic(0, 1'b0, 1'b0);
    check("wrap_cnt0", pkt_cnt0, 32'd0);
    add_pkt(0, 1, 16'h0008);
    build_expected();
    run_traffic(0, 1'b0, 1'b0);
    check("wrap_next_cnt0", pkt_cnt0, exp_cnt0);

    // clear_counters coincident with tlast acceptance
    b = rand_beat(16'h0008, 1'b1);
    @(negedge axis_aclk);
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = b;
    s0_axis_tvalid = 1'b1;
    @(negedge axis_aclk);
    clear_counters = 1'b1;
    #1 check("clr_tready", s0_axis_tready, 1'b1);
    @(negedge axis_aclk);
    clear_counters = 1'b0;
    s0_axis_tvalid = 1'b0;
    model_last = 0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    #1 check("clr_cnt0", pkt_cnt0, exp_cnt0);
    check("clr_cnt1", pkt_cnt1, exp_cnt1);
    check("clr_beat", out_beat(), b);
    @(negedge axis_aclk);

    // Randomized traffic with random backpressure
    reset_pulse();
    for (int r = 0; r < 3; r++) begin
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) add_pkt(0, $urandom_range(1, 6), 16'h0008);
      for (int i = 0; i < n1; i++) add_pkt(1, $urandom_range(1, 6), 16'h0008);
      build_expected();
      run_traffic(2, 1'b0, 1'b0);
      check("rand_cnt0", pkt_cnt0, exp_cnt0);
      check("rand_cnt1", pkt_cnt1, exp_cnt1);
    end

    // IPv4 on s0 versus ARP on s1 right after reset
    reset_pulse();
    add_pkt(0, 2, 16'h0008);
    add_pkt(1, 2, 16'h0608);
    build_expected();
    run_traffic(0, 1'b0, 1'b0);
    check("arp_cnt0", pkt_cnt0, exp_cnt0);
    check("arp_cnt1", pkt_cnt1, exp_cnt1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
